// File: rtl/counter_pkg.sv
// counter_pkg: FSM state type and load clamp shared by counter_modn.
package counter_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HOLD} cnt_state_t;
   function automatic int unsigned clamp(input int unsigned v, input int unsigned hi);
      return (v > hi) ? hi : v;
   endfunction
endpackage

// File: rtl/prescaler_tick.sv
// prescaler_tick: one-cycle tick every PRESCALE clk_in cycles; clr restarts the period.
module prescaler_tick #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk_in,
   input  logic reset,
   input  logic clr,
   output logic tick
);
   logic [15:0] cnt;
   assign tick = cnt == 16'(PRESCALE - 1);
   always_ff @(posedge clk_in or negedge reset)
      if (!reset) cnt <= '0;
      else if (clr || tick) cnt <= '0;
      else cnt <= cnt + 16'd1;
endmodule

// File: rtl/counter_modn.sv
// counter_modn: up/down modulo-MODULO counter with IDLE/RUN/HOLD one-shot control.
// Define COUNTER_PRESCALER_EN to step only once every PRESCALE clk_in cycles.
module counter_modn
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned MODULO   = 8,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             oneshot,
   input  logic             start,
   output logic [WIDTH-1:0] count,
   output logic             carry,
   output logic             busy
);
   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);
   cnt_state_t state, state_n;
   logic tick, step, wrap;
   logic [WIDTH-1:0] count_n;

   if (MODULO < 2 || MODULO > 2**WIDTH || PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_params
      $error("counter_modn: illegal WIDTH/MODULO/PRESCALE combination");
   end

`ifdef COUNTER_PRESCALER_EN
   // held clear outside RUN so each entry to RUN starts a fresh period
   prescaler_tick #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk_in (clk_in),
      .reset  (reset),
      .clr    (load || state != RUN),
      .tick   (tick)
   );
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      step    = state == RUN && en && tick && !load;
      wrap    = step && (up ? count == TOP : count == '0);
      count_n = load ? WIDTH'(clamp(32'(load_val), MODULO - 1))
              : !step ? count
              : wrap ? (up ? '0 : TOP)
              : up ? count + WIDTH'(1) : count - WIDTH'(1);
      state_n = (state != RUN && start) ? RUN
              : (wrap && oneshot) ? HOLD
              : state;
   end

   always_ff @(posedge clk_in or negedge reset)
      if (!reset) begin
         state <= IDLE;
         count <= '0;
         carry <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         carry <= wrap;
      end

   assign busy = state == RUN;
endmodule

// File: tb/tb_counter_modn.sv
// tb_counter_modn: four counter_modn instances on shared stimulus, checked against a reference model.
module tb_counter_modn;
`ifdef COUNTER_PRESCALER_EN
   localparam int P = 4;
`else
   localparam int P = 1;
`endif
   localparam int N = 4;

   logic clk = 0, reset = 1, en = 0, up = 1, load = 0, oneshot = 0, start = 0;
   logic [3:0] lv = '0;
   logic [2:0] c8, c6, c5;
   logic [3:0] c10;
   logic y8, y10, y6, y5, b8, b10, b6, b5;
   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   counter_modn #(.WIDTH(3), .MODULO(8), .PRESCALE(4)) d8 (.clk_in(clk), .reset(reset), .en(en), .up(up),
      .load(load), .load_val(lv[2:0]), .oneshot(oneshot), .start(start), .count(c8), .carry(y8), .busy(b8));
   counter_modn #(.WIDTH(4), .MODULO(10), .PRESCALE(4)) d10 (.clk_in(clk), .reset(reset), .en(en), .up(up),
      .load(load), .load_val(lv), .oneshot(oneshot), .start(start), .count(c10), .carry(y10), .busy(b10));
   counter_modn #(.WIDTH(3), .MODULO(6), .PRESCALE(4)) d6 (.clk_in(clk), .reset(reset), .en(en), .up(up),
      .load(load), .load_val(lv[2:0]), .oneshot(oneshot), .start(start), .count(c6), .carry(y6), .busy(b6));
   counter_modn #(.WIDTH(3), .MODULO(5), .PRESCALE(4)) d5 (.clk_in(clk), .reset(reset), .en(en), .up(up),
      .load(load), .load_val(lv[2:0]), .oneshot(oneshot), .start(start), .count(c5), .carry(y5), .busy(b5));

   function automatic int mod_of(input int i);
      return i == 0 ? 8 : i == 1 ? 10 : i == 2 ? 6 : 5;
   endfunction
   function automatic int wid_of(input int i);
      return i == 1 ? 4 : 3;
   endfunction
   function automatic logic [3:0] dut_cnt(input int i);
      return i == 0 ? {1'b0, c8} : i == 1 ? c10 : i == 2 ? {1'b0, c6} : {1'b0, c5};
   endfunction
   function automatic logic dut_car(input int i);
      return i == 0 ? y8 : i == 1 ? y10 : i == 2 ? y6 : y5;
   endfunction
   function automatic logic dut_busy(input int i);
      return i == 0 ? b8 : i == 1 ? b10 : i == 2 ? b6 : b5;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // reference model: mode 0 idle, 1 running, 2 held after a one-shot wrap
   int  m_cnt [N];
   int  m_mode [N];
   int  m_run_cyc [N];
   bit  m_car [N];

   always @(posedge clk or negedge reset) begin : model
      int m, lvw;
      bit run, tk, stp, wr;
      for (int i = 0; i < N; i++) begin
         if (!reset) begin
            m_cnt[i] <= 0; m_mode[i] <= 0; m_run_cyc[i] <= 0; m_car[i] <= 0;
         end else begin
            m = mod_of(i);
            lvw = int'(lv) % (1 << wid_of(i));
            run = m_mode[i] == 1;
            tk = (P == 1) || (m_run_cyc[i] % P == P - 1);
            stp = run && en && tk && !load;
            wr = stp && (up ? m_cnt[i] == m - 1 : m_cnt[i] == 0);
            m_car[i] <= wr;
            m_run_cyc[i] <= (!run || load) ? 0 : m_run_cyc[i] + 1;
            if (load) m_cnt[i] <= lvw < m ? lvw : m - 1;
            else if (stp) m_cnt[i] <= (m_cnt[i] + (up ? 1 : m - 1)) % m;
            m_mode[i] <= (m_mode[i] != 1 && start) ? 1 : (wr && oneshot) ? 2 : m_mode[i];
         end
      end
   end

   always @(negedge clk)
      for (int i = 0; i < N; i++) begin
         check($sformatf("model_count[%0d]", i), dut_cnt(i), m_cnt[i]);
         check($sformatf("model_carry[%0d]", i), dut_car(i), m_car[i]);
         check($sformatf("model_busy[%0d]", i), dut_busy(i), m_mode[i] == 1);
      end

   initial begin
      #1 reset = 0;
      repeat (2) @(posedge clk);
      #1 check("rst_count", c8, 0); check("rst_carry", y8, 0); check("rst_busy", b8, 0);
      @(negedge clk) reset = 1;

      // free-running up count through a full wrap
      @(negedge clk) begin en = 1; up = 1; oneshot = 0; start = 1; end
      @(negedge clk) start = 0;
      for (int k = 1; k <= 8 * P; k++) begin
         @(posedge clk) #1;
         check("up_count", c8, (k / P) % 8);
         check("up_carry", y8, k == 8 * P);
      end
      check("up_busy", b8, 1);
      check("prescale_rate", c10, 8);

      // down count from a loaded value across zero
      @(negedge clk) begin up = 0; load = 1; lv = 2; end
      @(negedge clk) load = 0;
      check("load_count", c10, 2);
      check("load_carry", y10, 0);
      for (int j = 1; j <= 3; j++) begin
         repeat (P) @(posedge clk);
         #1 check("down_count", c10, j == 1 ? 1 : j == 2 ? 0 : 9);
         check("down_carry", y10, j == 3);
      end

      // load beats step; out-of-range load values clamp to MODULO-1
      @(negedge clk) begin up = 1; lv = 4; load = 1; end
      @(negedge clk) lv = 7;
      @(negedge clk) load = 0;
      check("clamp_count5", c5, 4);
      check("clamp_carry5", y5, 0);
      check("clamp_count6", c6, 5);
      check("noclamp_count8", c8, 7);

      // one-shot: wrap into HOLD, stay frozen, restart on start
      @(negedge clk) reset = 0;
      @(negedge clk) begin reset = 1; oneshot = 1; up = 1; en = 1; start = 1; end
      @(negedge clk) start = 0;
      for (int k = 1; k <= 6 * P; k++) begin
         @(posedge clk) #1;
         check("oneshot_count", c6, (k / P) % 6);
      end
      check("oneshot_carry", y6, 1);
      check("oneshot_busy", b6, 0);
      repeat (10) begin
         @(posedge clk) #1;
         check("hold_count", c6, 0);
         check("hold_busy", b6, 0);
         check("hold_carry", y6, 0);
      end
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      check("restart_busy", b6, 1);
      check("restart_count0", c6, 0);
      repeat (P) @(posedge clk);
      #1 check("restart_count1", c6, 1);

      // asynchronous reset between edges aborts the count
      @(negedge clk) reset = 0;
      @(negedge clk) begin reset = 1; oneshot = 0; start = 1; end
      @(negedge clk) start = 0;
      repeat (5 * P) @(posedge clk);
      #1 check("pre_abort_count", c8, 5);
      #2 reset = 0;
      #1 check("abort_count", c8, 0); check("abort_busy", b8, 0); check("abort_carry", y8, 0);
      @(negedge clk) reset = 1;
      repeat (5) @(posedge clk);
      #1 check("idle_count", c8, 0); check("idle_busy", b8, 0);

      // randomized traffic, checked cycle by cycle against the model
      repeat (400) @(negedge clk) begin
         reset   = $urandom_range(0, 99) != 0;
         en      = $urandom_range(0, 3) != 0;
         up      = 1'($urandom);
         load    = $urandom_range(0, 11) == 0;
         lv      = 4'($urandom);
         oneshot = 1'($urandom);
         start   = $urandom_range(0, 5) == 0;
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
